mdr_sequencer: RTL and testbench

Iterative control and datapath stage that drives the MDR ALU. It accepts one multiply, divide or square-root request at a time and holds the working registers (accumulator, quotient/root, radicand). Each cycle it presents one iteration's operands to the ALU, consumes the ALU's add/sub/shift results, and reports a registered 2N-bit result with a one-cycle done pulse.

---
 rtl/mdr_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_mdr_sequencer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mdr_sequencer.sv
// mdr_sequencer: iterative multiply / divide / square-root control stage.
// Presents one iteration's operands per cycle to the external MDR ALU.
package mdr_pkg;
    localparam int DW_MDR        = 8;
    localparam int D_SHIFT_VALUE = 2*DW_MDR-2;
    typedef logic [DW_MDR-1:0]   data_bus_n;
    typedef logic [2*DW_MDR-1:0] data_bus_2n;
    typedef enum logic [1:0] {
        MULT       = 2'd0,
        DIV        = 2'd1,
        SQRT       = 2'd2,
        SQRT_FINAL = 2'd3
    } op_bus;
endpackage

module mdr_sequencer
    import mdr_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  op_bus                 op,
    input  logic [DW_MDR-1:0]     in_data_a,
    input  logic [DW_MDR-1:0]     in_data_b,
    output logic                  ready,
    output logic                  done,
    output logic                  error,
    output logic [DW_MDR-1:0]     result_hi,
    output logic [DW_MDR-1:0]     result_lo,
    output logic [DW_MDR-1:0]     alu_value_x,
    output logic [2*DW_MDR-1:0]   alu_value_d,
    output logic [DW_MDR-1:0]     alu_operator_a,
    output logic [DW_MDR-1:0]     alu_operator_b,
    output op_bus                 alu_select,
    input  logic [DW_MDR-1:0]     alu_add,
    input  logic [DW_MDR-1:0]     alu_sub,
    input  logic [DW_MDR-1:0]     alu_shift
);
    localparam int N  = DW_MDR;
    localparam int CW = $clog2(N+1);

    typedef enum logic [1:0] {IDLE, RUN, FINAL, DONE} state_t;

    state_t          state;
    op_bus           op_r;
    logic [N-1:0]    acc;
    logic [N-1:0]    q_r;
    logic [N-1:0]    x_r;
    logic [2*N-1:0]  d_r;
    logic [CW-1:0]   cnt;

    logic [N-1:0]    div_opa;
    logic [N-1:0]    mul_sum;
    logic            mul_carry;
    logic            div_ge;
    logic [N-1:0]    sqrt_a;
    logic [N-1:0]    acc_nx;
    logic [N-1:0]    q_nx;

    assign div_opa   = {acc[N-2:0], q_r[N-1]};
    assign mul_sum   = q_r[0] ? alu_add : alu_shift;
    assign mul_carry = q_r[0] & (alu_add < acc);
    assign div_ge    = acc[N-1] | (div_opa >= x_r);
    assign sqrt_a    = acc[N-1] ? alu_add : alu_sub;

    always_comb begin
        alu_select     = MULT;
        alu_operator_a = '0;
        alu_operator_b = '0;
        alu_value_x    = '0;
        alu_value_d    = '0;
        if (state == RUN) begin
            case (op_r)
                MULT: begin
                    alu_operator_a = acc;
                    alu_value_x    = x_r;
                end
                DIV: begin
                    alu_select     = DIV;
                    alu_operator_a = div_opa;
                    alu_value_x    = x_r;
                end
                default: begin
                    alu_select     = SQRT;
                    alu_operator_a = acc;
                    alu_operator_b = q_r;
                    alu_value_d    = d_r;
                end
            endcase
        end else if (state == FINAL) begin
            alu_select     = SQRT_FINAL;
            alu_operator_a = acc;
            alu_operator_b = q_r;
        end
    end

    always_comb begin
        acc_nx = acc;
        q_nx   = q_r;
        if (state == RUN) begin
            case (op_r)
                MULT: {acc_nx, q_nx} = {mul_carry, mul_sum, q_r[N-1:1]};
                DIV: begin
                    acc_nx = div_ge ? alu_sub : div_opa;
                    q_nx   = {q_r[N-2:0], div_ge};
                end
                default: begin
                    acc_nx = sqrt_a;
                    q_nx   = {q_r[N-2:0], ~sqrt_a[N-1]};
                end
            endcase
        end else if (state == FINAL) begin
            acc_nx = acc[N-1] ? alu_add : acc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            op_r      <= MULT;
            acc       <= '0;
            q_r       <= '0;
            x_r       <= '0;
            d_r       <= '0;
            cnt       <= '0;
            ready     <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
            result_hi <= '0;
            result_lo <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start && ready) begin
                        ready <= 1'b0;
                        error <= 1'b0;
                        op_r  <= op;
                        acc   <= '0;
                        q_r   <= '0;
                        x_r   <= in_data_b;
                        d_r   <= '0;
                        cnt   <= CW'(N);
                        state <= RUN;
                        case (op)
                            MULT: q_r <= in_data_a;
                            DIV: begin
                                q_r <= in_data_a;
                                if (in_data_b == '0) begin
                                    error     <= 1'b1;
                                    result_lo <= '1;
                                    result_hi <= in_data_a;
                                    state     <= DONE;
                                end
                            end
                            SQRT: begin
                                d_r <= {in_data_a, {N{1'b0}}};
                                cnt <= CW'(N/2);
                            end
                            default: begin
                                error     <= 1'b1;
                                result_lo <= '0;
                                result_hi <= '0;
                                state     <= DONE;
                            end
                        endcase
                    end else begin
                        ready <= 1'b1;
                    end
                end
                RUN: begin
                    acc <= acc_nx;
                    q_r <= q_nx;
                    d_r <= {d_r[2*N-3:0], 2'b00};
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        if (op_r == SQRT) begin
                            state <= FINAL;
                        end else begin
                            result_hi <= acc_nx;
                            result_lo <= q_nx;
                            state     <= DONE;
                        end
                    end
                end
                FINAL: begin
                    acc       <= acc_nx;
                    result_hi <= acc_nx;
                    result_lo <= q_r;
                    state     <= DONE;
                end
                DONE: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mdr_sequencer.sv
// Bench for mdr_sequencer: behavioural ALU, vector table, random ops
// against an arithmetic reference, plus reset / busy-start sequences.
module tb_mdr_sequencer;
    import mdr_pkg::*;
    localparam int N = DW_MDR;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    op_bus          op;
    logic [N-1:0]   in_data_a, in_data_b;
    logic           ready, done, error;
    logic [N-1:0]   result_hi, result_lo;
    logic [N-1:0]   alu_value_x, alu_operator_a, alu_operator_b;
    logic [2*N-1:0] alu_value_d;
    op_bus          alu_select;
    logic [N-1:0]   alu_add, alu_sub, alu_shift;
    logic [N-1:0]   rs;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cnt = 0;
    int done_cnt = 0;
    int overlap = 0;

    mdr_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .in_data_a(in_data_a), .in_data_b(in_data_b),
        .ready(ready), .done(done), .error(error),
        .result_hi(result_hi), .result_lo(result_lo),
        .alu_value_x(alu_value_x), .alu_value_d(alu_value_d),
        .alu_operator_a(alu_operator_a), .alu_operator_b(alu_operator_b),
        .alu_select(alu_select),
        .alu_add(alu_add), .alu_sub(alu_sub), .alu_shift(alu_shift)
    );

    always #5 clk = ~clk;

    // Behavioural MDR ALU
    assign rs = {alu_operator_a[N-3:0],
                 alu_value_d[D_SHIFT_VALUE+1:D_SHIFT_VALUE]};
    always_comb begin
        alu_add   = '0;
        alu_sub   = '0;
        alu_shift = alu_operator_a;
        case (alu_select)
            MULT: alu_add = alu_operator_a + alu_value_x;
            DIV:  alu_sub = alu_operator_a - alu_value_x;
            SQRT: begin
                alu_add = rs + {alu_operator_b[N-3:0], 2'b11};
                alu_sub = rs - {alu_operator_b[N-3:0], 2'b01};
            end
            default: alu_add = alu_operator_a + {alu_operator_b[N-2:0], 1'b1};
        endcase
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && start && ready) acc_cnt <= acc_cnt + 1;
    end

    always @(negedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
        if (done && ready) overlap <= overlap + 1;
    end

    typedef struct {
        string        nm;
        op_bus        op;
        logic [N-1:0] a, b;
        logic         err;
        logic [N-1:0] hi, lo;
        int           lat;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic void ref_model(input op_bus o, input int a, input int b,
                                      output logic e, output int hi,
                                      output int lo, output int lat);
        int r;
        e = 0; hi = 0; lo = 0; lat = N + 1;
        case (o)
            MULT: begin
                hi = (a * b) / (1 << N);
                lo = (a * b) % (1 << N);
            end
            DIV: begin
                if (b == 0) begin
                    e = 1; hi = a; lo = (1 << N) - 1; lat = 1;
                end else begin
                    hi = a % b; lo = a / b;
                end
            end
            SQRT: begin
                r = 0;
                while ((r + 1) * (r + 1) <= a) r++;
                lo = r; hi = a - r * r; lat = N/2 + 2;
            end
            default: begin
                e = 1; lat = 1;
            end
        endcase
    endfunction

    task automatic run_op(input string nm, input op_bus o,
                          input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic e_err, input logic [N-1:0] e_hi,
                          input logic [N-1:0] e_lo, input int e_lat);
        int t0, w;
        w = 0;
        @(negedge clk);
        while (!ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk({nm, ".ready_idle"}, ready, 1);
        start = 1'b1; op = o; in_data_a = a; in_data_b = b;
        t0 = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        in_data_a = N'($urandom);
        in_data_b = N'($urandom);
        chk({nm, ".ready_busy"}, ready, 0);
        w = 0;
        while (!done && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk({nm, ".latency"}, cyc - t0, e_lat);
        chk({nm, ".error"}, error, e_err);
        chk({nm, ".hi"}, result_hi, e_hi);
        chk({nm, ".lo"}, result_lo, e_lo);
        chk({nm, ".ready_at_done"}, ready, 0);
        @(negedge clk);
        chk({nm, ".done_pulse"}, done, 0);
        chk({nm, ".ready_back"}, ready, 1);
        chk({nm, ".lo_held"}, result_lo, e_lo);
    endtask

    initial begin
        int d0, a0, ehi, elo, elat;
        logic eerr;
        op_bus ro;
        logic [N-1:0] ra, rb;

        tbl[0] = '{"mul_ff_ff", MULT, 8'hFF, 8'hFF, 1'b0, 8'hFE, 8'h01, 9};
        tbl[1] = '{"div_200_7", DIV, 8'd200, 8'd7, 1'b0, 8'h04, 8'h1C, 9};
        tbl[2] = '{"div_80_1", DIV, 8'h80, 8'h01, 1'b0, 8'h00, 8'h80, 9};
        tbl[3] = '{"div_by_0", DIV, 8'h55, 8'h00, 1'b1, 8'h55, 8'hFF, 1};
        tbl[4] = '{"sqrt_200", SQRT, 8'd200, 8'h00, 1'b0, 8'd4, 8'd14, 6};
        tbl[5] = '{"sqrt_255", SQRT, 8'd255, 8'h3C, 1'b0, 8'd30, 8'd15, 6};
        tbl[6] = '{"sqrt_0", SQRT, 8'd0, 8'h00, 1'b0, 8'd0, 8'd0, 6};
        tbl[7] = '{"illegal", SQRT_FINAL, 8'h12, 8'h34, 1'b1, 8'd0, 8'd0, 1};
        tbl[8] = '{"mul_0_x", MULT, 8'h00, 8'hA5, 1'b0, 8'd0, 8'd0, 9};

        rst = 1'b1; start = 1'b0; op = MULT; in_data_a = '0; in_data_b = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset.ready", ready, 1);
        chk("reset.done", done, 0);
        chk("reset.error", error, 0);
        chk("reset.hi", result_hi, 0);
        chk("reset.lo", result_lo, 0);
        chk("reset.alu_sel", alu_select, MULT);
        chk("reset.alu_ops", {alu_operator_a, alu_operator_b, alu_value_x, alu_value_d}, 0);

        for (int i = 0; i < 9; i++)
            run_op(tbl[i].nm, tbl[i].op, tbl[i].a, tbl[i].b,
                   tbl[i].err, tbl[i].hi, tbl[i].lo, tbl[i].lat);

        for (int i = 0; i < 40; i++) begin
            ro = op_bus'($urandom_range(0, 3));
            ra = N'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
            ref_model(ro, int'(ra), int'(rb), eerr, ehi, elo, elat);
            run_op($sformatf("rnd%0d", i), ro, ra, rb, eerr, N'(ehi), N'(elo), elat);
        end

        // Reset in the middle of a multiply
        @(negedge clk);
        start = 1'b1; op = MULT; in_data_a = 8'h77; in_data_b = 8'h99;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        d0 = done_cnt;
        rst = 1'b1;
        #1;
        chk("rst_mid.ready", ready, 1);
        chk("rst_mid.hi", result_hi, 0);
        chk("rst_mid.lo", result_lo, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid.ready_after", ready, 1);
        chk("rst_mid.error", error, 0);
        repeat (15) @(negedge clk);
        chk("rst_mid.no_done", done_cnt - d0, 0);
        run_op("mul_3_5", MULT, 8'd3, 8'd5, 1'b0, 8'd0, 8'd15, 9);

        // Start pulse while busy must be ignored
        d0 = done_cnt;
        @(negedge clk);
        start = 1'b1; op = MULT; in_data_a = 8'h12; in_data_b = 8'h34;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1; op = DIV; in_data_a = 8'h09; in_data_b = 8'h00;
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        chk("busy.one_done", done_cnt - d0, 1);
        chk("busy.hi", result_hi, 8'h03);
        chk("busy.lo", result_lo, 8'hA8);
        chk("busy.error", error, 0);

        // Continuous start: one done per accepted op
        d0 = done_cnt;
        a0 = acc_cnt;
        overlap = 0;
        start = 1'b1; op = SQRT; in_data_a = 8'd200; in_data_b = 8'd0;
        repeat (60) @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        chk("cont.accepts", (acc_cnt - a0) >= 5, 1);
        chk("cont.done_eq_acc", done_cnt - d0, acc_cnt - a0);
        chk("cont.no_overlap", overlap, 0);
        chk("cont.lo", result_lo, 14);
        chk("cont.hi", result_hi, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
